seq_detect_prog: RTL and testbench

Programmable serial bit-pattern detector: the parametrised successor of the team's fixed 4-bit Moore sequence detector. It accepts one serial bit per qualified clock and compares it against a runtime-loadable pattern of length 1..N. The pattern is selectable as overlapping or non-overlapping, and the block flags each match with a registered (Moore) pulse. It sits in front of frame/sync logic that needs a sync-word hit and, optionally, a hit count.

---
 rtl/seq_detect_prog.sv | 119 +++++++++++
 tb/tb_seq_detect_prog.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable serial bit-pattern detector.
// Compares a serial bit stream against a runtime-loadable pattern of length
// 1..N, with overlapping or non-overlapping detection, and raises a registered
// (Moore) match flag z for one cycle per hit.
// Optional feature macro: SEQ_DETECT_PROG_CNT_EN builds the saturating
// match counter; without it match_cnt is tied to zero.
module seq_detect_prog #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   DEF_PAT = 4'b0110,
  parameter int             CNT_W   = 8,
  localparam int            LW      = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  input  logic [LW-1:0]    len_in,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  // Only the newest N-1 samples are kept: together with the incoming bit they
  // form the N-bit comparison window, so the oldest bit is never needed.
  logic [N-1:0]  pat_q, pat_d;
  logic [LW-1:0] len_q, len_d;
  logic [N-2:0]  hist_q, hist_d;
  logic [LW-1:0] fill_q, fill_d;
  logic          z_q, z_d;

  logic [N-1:0]  window;
  logic [N-1:0]  len_mask;
  logic [LW-1:0] fill_inc;
  logic          hit;
  logic          valid_hit;

  // Match evaluation on the window that includes the current bit.
  always_comb begin
    window   = {hist_q, x};
    fill_inc = (fill_q >= LW'(N)) ? LW'(N) : fill_q + 1'b1;
    len_mask = '0;
    for (int i = 0; i < N; i++) begin
      len_mask[i] = (LW'(i) < len_q);
    end
    hit       = (fill_inc >= len_q) && ((window & len_mask) == (pat_q & len_mask));
    valid_hit = in_valid && !pat_load && hit;
  end

  // Next-state for pattern, length, history, fill and match flag.
  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    hist_d = hist_q;
    fill_d = fill_q;
    z_d    = 1'b0;
    if (pat_load) begin
      pat_d  = pat_in;
      len_d  = ((len_in == '0) || (len_in > LW'(N))) ? LW'(N) : len_in;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = window[N-2:0];
      // Non-overlapping: a hit consumes its whole window.
      fill_d = (hit && !overlap) ? '0 : fill_inc;
      z_d    = hit;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= DEF_PAT;
      len_q  <= LW'(N);
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q    <= z_d;
    end
  end

  assign z = z_q;

`ifdef SEQ_DETECT_PROG_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating hit counter, cleared by a pattern load.
  always_comb begin
    cnt_d = cnt_q;
    if (pat_load) begin
      cnt_d = '0;
    end else if (valid_hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  logic unused_hit;
  assign unused_hit = valid_hit;
  assign match_cnt  = '0;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Testbench for seq_detect_prog: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model of the matching rules.
module tb_seq_detect_prog;
  localparam int N     = 4;
  localparam int LW    = $clog2(N + 1);
  localparam int CNT_W = 2;
  localparam logic [N-1:0] DEF_PAT = 4'b0110;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             x = 1'b0;
  logic             in_valid = 1'b0;
  logic             overlap = 1'b0;
  logic             pat_load = 1'b0;
  logic [N-1:0]     pat_in = '0;
  logic [LW-1:0]    len_in = '0;
  logic             z;
  logic [CNT_W-1:0] match_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: received bits since last clear, oldest first.
  bit           hq[$];
  logic [N-1:0] mpat;
  int           mlen;
  logic         mz;
  int           mcnt;
  int           exp_cnt;

  seq_detect_prog #(.N(N), .DEF_PAT(DEF_PAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .len_in(len_in),
    .z(z), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, then advance the reference model.
  task automatic drive(input logic r, input logic ld, input logic v, input logic xb,
                       input logic ov, input logic [N-1:0] pin, input logic [LW-1:0] lin);
    bit ok;
    reset = r; pat_load = ld; in_valid = v; x = xb; overlap = ov;
    pat_in = pin; len_in = lin;
    @(posedge clk);
    #1;
    if (r) begin
      mpat = DEF_PAT; mlen = N; hq.delete(); mz = 1'b0; mcnt = 0;
    end else if (ld) begin
      mpat = pin;
      mlen = (lin == 0 || int'(lin) > N) ? N : int'(lin);
      hq.delete(); mz = 1'b0; mcnt = 0;
    end else if (v) begin
      hq.push_back(xb);
      if (hq.size() > N) void'(hq.pop_front());
      ok = (hq.size() >= mlen);
      for (int i = 0; i < mlen && ok; i++)
        if (hq[hq.size() - 1 - i] != mpat[i]) ok = 1'b0;
      mz = ok;
      if (ok) begin
        if (mcnt < (1 << CNT_W) - 1) mcnt++;
        if (!ov) hq.delete();
      end
    end else begin
      mz = 1'b0;
    end
`ifdef SEQ_DETECT_PROG_CNT_EN
    exp_cnt = mcnt;
`else
    exp_cnt = 0;
`endif
    vectors++;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, '0, '0);
    if (z !== 1'b0 || match_cnt !== CNT_W'(0)) begin
      miscompares++;
      $display("FAIL reset: z=%b cnt=%0d, expected z=0 cnt=0", z, match_cnt);
    end
  endtask

  task automatic test_stream(input logic ov, input string name);
    logic [10:0] s;
    s = 11'b01101100110;
    drive(1'b1, 1'b0, 1'b0, 1'b0, ov, '0, '0);
    for (int i = 10; i >= 0; i--) begin
      drive(1'b0, 1'b0, 1'b1, s[i], ov, '0, '0);
      if (z !== mz || match_cnt !== CNT_W'(exp_cnt)) begin
        miscompares++;
        $display("FAIL %s bit %0d: z=%b cnt=%0d, expected z=%b cnt=%0d",
                 name, 11 - i, z, match_cnt, mz, exp_cnt);
      end
    end
  endtask

  task automatic test_gaps();
    logic [3:0] s;
    int pulses;
    s = 4'b0110;
    pulses = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    for (int i = 3; i >= 0; i--) begin
      drive(1'b0, 1'b0, 1'b1, s[i], 1'b1, '0, '0);
      if (z) pulses++;
      if (z !== mz) begin
        miscompares++;
        $display("FAIL gaps bit %0d: z=%b, expected %b", 4 - i, z, mz);
      end
      for (int g = 0; g < 3; g++) begin
        drive(1'b0, 1'b0, 1'b0, $urandom_range(0, 1), 1'b1, '0, '0);
        if (z) pulses++;
        if (z !== 1'b0) begin
          miscompares++;
          $display("FAIL gaps idle: z=%b, expected 0", z);
        end
      end
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL gaps pulses: got %0d, expected 1", pulses);
    end
  endtask

  task automatic test_load(input logic [LW-1:0] lin, input string name);
    logic [4:0] s;
    s = 5'b10101;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0101, lin);
    if (z !== 1'b0 || match_cnt !== CNT_W'(0)) begin
      miscompares++;
      $display("FAIL %s load: z=%b cnt=%0d, expected z=0 cnt=0", name, z, match_cnt);
    end
    for (int i = 4; i >= 0; i--) begin
      drive(1'b0, 1'b0, 1'b1, s[i], 1'b1, '0, '0);
      if (z !== mz || match_cnt !== CNT_W'(exp_cnt)) begin
        miscompares++;
        $display("FAIL %s bit %0d: z=%b cnt=%0d, expected z=%b cnt=%0d",
                 name, 5 - i, z, match_cnt, mz, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s;
    logic [7:0] rst_at;
    s      = 8'b0110_0110;
    rst_at = 8'b0001_0000;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, '0, '0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, '0, '0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, '0, '0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, '0, '0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, (i == 0) ? 1'b0 : s[4 - i], 1'b1, '0, '0);
      if (z !== mz || match_cnt !== CNT_W'(exp_cnt)) begin
        miscompares++;
        $display("FAIL reset_mid bit %0d: z=%b cnt=%0d, expected z=%b cnt=%0d",
                 i, z, match_cnt, mz, exp_cnt);
      end
    end
    vectors++;
    if (z !== 1'b1 || rst_at[4] !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid final: z=%b, expected 1", z);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 3'd1);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
`ifdef SEQ_DETECT_PROG_CNT_EN
      if (z !== 1'b1 || match_cnt !== CNT_W'((i > 3) ? 3 : i)) begin
`else
      if (z !== 1'b1 || match_cnt !== CNT_W'(0)) begin
`endif
        miscompares++;
        $display("FAIL saturate hit %0d: z=%b cnt=%0d, expected z=1 cnt=%0d",
                 i, z, match_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      drive(r < 2, r >= 2 && r < 6, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
            $urandom_range(0, 7) != 0, N'($urandom), LW'($urandom_range(0, 7)));
      if (z !== mz || match_cnt !== CNT_W'(exp_cnt)) begin
        miscompares++;
        $display("FAIL random cyc %0d: z=%b cnt=%0d, expected z=%b cnt=%0d",
                 i, z, match_cnt, mz, exp_cnt);
      end
    end
  endtask

  initial begin
    mpat = DEF_PAT; mlen = N; mz = 1'b0; mcnt = 0; exp_cnt = 0;
    test_reset();
    test_stream(1'b1, "overlap");
    test_stream(1'b0, "nonoverlap");
    test_gaps();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    test_load(3'd3, "load_len3");
    test_load(3'd0, "load_len0");
    test_load(3'd6, "load_len6");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
